accum_sequencer: RTL and testbench

Shared-accumulator controller: arbitrates two requesters (A, B) onto one WIDTH-bit accumulator and sequences each operation (add, subtract, load, clear) through a fixed three-state FSM. Returns a one-cycle acknowledge to the served requester. Drives the accumulator value and carry/signed-overflow flags to the board-level display logic.

---
 rtl/accum_sequencer_pkg.sv | 41 ++++
 rtl/accum_sequencer_alu.sv | 48 ++++
 rtl/accum_sequencer.sv | 124 ++++++++++++
 tb/tb_accum_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_sequencer_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, FSM states,
// requester identifiers and the round-robin winner selection.
package accum_sequencer_pkg;

  // Opcode encoding as presented on OP_A / OP_B.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CLR  = 2'b11
  } op_t;

  // Sequencer states; 2'b11 is never entered and falls back to idle.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXEC   = 2'b01,
    S_ACK    = 2'b10,
    S_UNUSED = 2'b11
  } state_t;

  // Requester identifiers used for the winner and last-served registers.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Round-robin pick: a lone requester always wins; on a tie the one that
  // was not served last wins. Callers only use this when a request is up.
  function automatic logic pick_winner(input logic req_a,
                                       input logic req_b,
                                       input logic last);
    logic win;
    if (req_a && req_b) begin
      win = ~last;
    end else if (req_a) begin
      win = SEL_A;
    end else begin
      win = SEL_B;
    end
    return win;
  endfunction

endpackage

// File: rtl/accum_sequencer_alu.sv
// Combinational accumulator ALU: given the current accumulator X, latched
// operand Y and opcode OP, produce the next accumulator value and flags.
module accum_alu
  import accum_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [1:0]       OP,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY,
  output logic             OVERFLOW
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  // One extra bit on the adder captures the carry out.
  assign sum  = {1'b0, X} + {1'b0, Y};
  assign diff = X - Y;

  // Select result and flags by opcode; load/clear leave both flags low.
  always_comb begin
    RESULT   = '0;
    CARRY    = 1'b0;
    OVERFLOW = 1'b0;
    case (OP)
      OP_ADD: begin
        RESULT   = sum[WIDTH-1:0];
        CARRY    = sum[WIDTH];
        OVERFLOW = (X[WIDTH-1] == Y[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
      end
      OP_SUB: begin
        RESULT   = diff;
        CARRY    = (X >= Y);
        OVERFLOW = (X[WIDTH-1] != Y[WIDTH-1]) && (diff[WIDTH-1] != X[WIDTH-1]);
      end
      OP_LOAD: begin
        RESULT = Y;
      end
      default: begin
        RESULT = '0;
      end
    endcase
  end

endmodule

// File: rtl/accum_sequencer.sv
// Shared-accumulator controller: round-robin arbitration of two requesters
// onto one accumulator, each operation sequenced IDLE -> EXEC -> ACK.
//
// Handshake: a requester raises REQ_x with OP_x/DATA_x and holds REQ_x until
// it sees ACK_x. REQ is only looked at in IDLE; the operand is captured on
// the edge that leaves IDLE, so OP/DATA may change afterwards. ACK_x is a
// single-cycle pulse during which ACC/CARRY/OVERFLOW already hold the result.
// REQ_x still high in the IDLE cycle after ACK_x counts as a new request.
module accum_sequencer
  import accum_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ_A,
  input  logic             REQ_B,
  input  logic [1:0]       OP_A,
  input  logic [1:0]       OP_B,
  input  logic [WIDTH-1:0] DATA_A,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             GNT_A,
  output logic             GNT_B,
  output logic             ACK_A,
  output logic             ACK_B,
  output logic [WIDTH-1:0] ACC,
  output logic             CARRY,
  output logic             OVERFLOW,
  output logic             BUSY,
  output logic [1:0]       STATE
);

  state_t           state_q;
  state_t           state_d;
  logic             last_q;
  logic             winner_q;
  logic             arb_winner;
  logic             any_req;
  logic             take_req;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             ovf_q;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_ovf;

  assign any_req    = REQ_A | REQ_B;
  assign arb_winner = pick_winner(REQ_A, REQ_B, last_q);
  assign take_req   = (state_q == S_IDLE) && any_req;

  accum_alu #(.WIDTH(WIDTH)) u_alu (
    .X        (acc_q),
    .Y        (data_q),
    .OP       (op_q),
    .RESULT   (alu_result),
    .CARRY    (alu_carry),
    .OVERFLOW (alu_ovf)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave IDLE on any request, then EXEC and ACK last one cycle each.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_EXEC;
      S_EXEC:  state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture winner and its operand when a request is accepted; last-served
  // resets to B so that A takes the first tie.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_q   <= SEL_B;
      winner_q <= SEL_A;
      op_q     <= OP_ADD;
      data_q   <= '0;
    end else if (take_req) begin
      last_q   <= arb_winner;
      winner_q <= arb_winner;
      op_q     <= (arb_winner == SEL_B) ? OP_B : OP_A;
      data_q   <= (arb_winner == SEL_B) ? DATA_B : DATA_A;
    end
  end

  // Accumulator and flags change only on the edge that closes EXEC.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == S_EXEC) begin
      acc_q   <= alu_result;
      carry_q <= alu_carry;
      ovf_q   <= alu_ovf;
    end
  end

  // Outputs decoded from the registered state and winner.
  always_comb begin
    GNT_A    = (state_q == S_EXEC) && (winner_q == SEL_A);
    GNT_B    = (state_q == S_EXEC) && (winner_q == SEL_B);
    ACK_A    = (state_q == S_ACK)  && (winner_q == SEL_A);
    ACK_B    = (state_q == S_ACK)  && (winner_q == SEL_B);
    BUSY     = (state_q != S_IDLE);
    STATE    = state_q;
    ACC      = acc_q;
    CARRY    = carry_q;
    OVERFLOW = ovf_q;
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// Testbench for accum_sequencer: directed test-plan steps followed by random
// operations, all checked against an arithmetic reference model.
module tb_accum_sequencer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         REQ_A, REQ_B;
  logic [1:0]   OP_A, OP_B;
  logic [W-1:0] DATA_A, DATA_B;
  logic         GNT_A, GNT_B, ACK_A, ACK_B;
  logic [W-1:0] ACC;
  logic         CARRY, OVERFLOW, BUSY;
  logic [1:0]   STATE;

  accum_sequencer #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .REQ_A    (REQ_A),
    .REQ_B    (REQ_B),
    .OP_A     (OP_A),
    .OP_B     (OP_B),
    .DATA_A   (DATA_A),
    .DATA_B   (DATA_B),
    .GNT_A    (GNT_A),
    .GNT_B    (GNT_B),
    .ACK_A    (ACK_A),
    .ACK_B    (ACK_B),
    .ACC      (ACC),
    .CARRY    (CARRY),
    .OVERFLOW (OVERFLOW),
    .BUSY     (BUSY),
    .STATE    (STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard and model ----------------
  int n_assert = 0;
  int n_fail   = 0;

  int   m_acc;
  logic m_carry;
  logic m_ovf;
  int   m_last;      // 0 = A served last, 1 = B served last
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  task automatic model_reset();
    m_acc   = 0;
    m_carry = 1'b0;
    m_ovf   = 1'b0;
    m_last  = 1;
  endtask

  // Apply an operation to the model using plain integer arithmetic.
  task automatic model_op(input int op, input int d);
    int a;
    int s;
    a = m_acc;
    case (op)
      0: begin
        s       = a + d;
        m_carry = (s > 255);
        m_acc   = s % 256;
        s       = sgn(a) + sgn(d);
        m_ovf   = (s > 127) || (s < -128);
      end
      1: begin
        m_carry = (a >= d);
        m_acc   = (a - d + 256) % 256;
        s       = sgn(a) - sgn(d);
        m_ovf   = (s > 127) || (s < -128);
      end
      2: begin
        m_acc   = d;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
      end
      default: begin
        m_acc   = 0;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
      end
    endcase
    exp_q.push_back(m_acc[W-1:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    check({tag, "_state"}, STATE, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_ack"}, {ACK_A, ACK_B}, 0);
    check({tag, "_gnt"}, {GNT_A, GNT_B}, 0);
  endtask

  // Issue one request pattern and follow it through EXEC, ACK and back to IDLE.
  task automatic run_op(input logic ra, input logic rb,
                        input logic [1:0] oa, input logic [1:0] ob,
                        input logic [W-1:0] da, input logic [W-1:0] db);
    int win;
    logic [W-1:0] old_acc;
    logic [W-1:0] exp_acc;
    REQ_A = ra; REQ_B = rb;
    OP_A = oa; OP_B = ob;
    DATA_A = da; DATA_B = db;
    win = (ra && rb) ? (1 - m_last) : (ra ? 0 : 1);
    m_last  = win;
    old_acc = m_acc[W-1:0];
    model_op(win ? int'(ob) : int'(oa), win ? int'(db) : int'(da));

    @(posedge CLK); #1;
    check("exec_gnt_a", GNT_A, win == 0);
    check("exec_gnt_b", GNT_B, win == 1);
    check("exec_ack", {ACK_A, ACK_B}, 0);
    check("exec_busy", BUSY, 1);
    check("exec_state", STATE, 1);
    check("exec_acc_hold", ACC, old_acc);
    // Operands were captured on entry to EXEC; disturb them.
    OP_A = 2'($urandom); OP_B = 2'($urandom);
    DATA_A = W'($urandom); DATA_B = W'($urandom);

    @(posedge CLK); #1;
    exp_acc = exp_q.pop_front();
    check("ack_a", ACK_A, win == 0);
    check("ack_b", ACK_B, win == 1);
    check("ack_gnt", {GNT_A, GNT_B}, 0);
    check("ack_acc", ACC, exp_acc);
    check("ack_carry", CARRY, m_carry);
    check("ack_ovf", OVERFLOW, m_ovf);
    check("ack_busy", BUSY, 1);
    check("ack_state", STATE, 2);
    REQ_A = 1'b0; REQ_B = 1'b0;

    @(posedge CLK); #1;
    check_idle("post");
    check("post_acc", ACC, exp_acc);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [1:0] r;
    int win;
    RESET = 1'b0;
    REQ_A = 1'b0; REQ_B = 1'b0;
    OP_A = 2'b00; OP_B = 2'b00;
    DATA_A = '0; DATA_B = '0;
    model_reset();

    // Reset values
    #12;
    check_idle("rst");
    check("rst_acc", ACC, 0);
    check("rst_flags", {CARRY, OVERFLOW}, 0);
    @(negedge CLK); RESET = 1'b1;
    @(posedge CLK); #1;
    check_idle("idle_noreq");

    // A loads 0x7F
    run_op(1, 0, 2'b10, 2'b00, 8'h7F, 8'h00);
    // B adds 0x01 -> 0x80, signed overflow
    run_op(0, 1, 2'b00, 2'b00, 8'h00, 8'h01);
    check("ovf_add1", {ACC, CARRY, OVERFLOW}, {8'h80, 1'b0, 1'b1});
    // A adds 0x80 -> 0x00, carry and overflow
    run_op(1, 0, 2'b00, 2'b00, 8'h80, 8'h00);
    check("ovf_add2", {ACC, CARRY, OVERFLOW}, {8'h00, 1'b1, 1'b1});
    // B clears with data 0xAA
    run_op(0, 1, 2'b00, 2'b11, 8'h00, 8'hAA);
    check("clr_flags", {ACC, CARRY, OVERFLOW}, {8'h00, 1'b0, 1'b0});
    // 0x05 - 0x07 borrows
    run_op(1, 0, 2'b10, 2'b00, 8'h05, 8'h00);
    run_op(1, 0, 2'b01, 2'b00, 8'h07, 8'h00);
    check("sub_borrow", {ACC, CARRY, OVERFLOW}, {8'hFE, 1'b0, 1'b0});
    // 0x80 - 0x01 overflows without borrow
    run_op(1, 0, 2'b10, 2'b00, 8'h80, 8'h00);
    run_op(0, 1, 2'b00, 2'b01, 8'h00, 8'h01);
    check("sub_ovf", {ACC, CARRY, OVERFLOW}, {8'h7F, 1'b1, 1'b1});

    // Reset during EXEC of an A add
    REQ_A = 1'b1; REQ_B = 1'b0; OP_A = 2'b00; DATA_A = 8'h10;
    @(posedge CLK); #1;
    check("mid_gnt_a", GNT_A, 1);
    RESET = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_acc", ACC, 0);
    model_reset();
    @(posedge CLK); #1;
    check("mid_no_ack", {ACK_A, ACK_B}, 0);
    REQ_A = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    // Tie after release goes to A
    run_op(1, 1, 2'b00, 2'b00, 8'h03, 8'h05);
    check("mid_tie_acc", ACC, 8'h03);

    // Fairness: both requesting from reset, both adding 1
    RESET = 1'b0;
    REQ_A = 1'b1; REQ_B = 1'b1;
    OP_A = 2'b00; OP_B = 2'b00;
    DATA_A = 8'h01; DATA_B = 8'h01;
    model_reset();
    @(posedge CLK); @(negedge CLK); RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      win = 1 - m_last;
      m_last = win;
      model_op(0, 1);
      @(posedge CLK); #1;
      check("fair_gnt_a", GNT_A, win == 0);
      check("fair_gnt_b", GNT_B, win == 1);
      check("fair_gnt_alt", GNT_A, (i % 2) == 0);
      @(posedge CLK); #1;
      check("fair_ack", {ACK_A, ACK_B}, (win == 0) ? 2'b10 : 2'b01);
      check("fair_acc", ACC, exp_q.pop_front());
      @(posedge CLK); #1;
      check("fair_idle", STATE, 0);
    end
    check("fair_acc4", ACC, 8'h04);
    REQ_A = 1'b0; REQ_B = 1'b0;
    @(posedge CLK); #1;
    check_idle("fair_end");

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      r = 2'($urandom_range(0, 3));
      if (r == 2'b00) begin
        @(posedge CLK); #1;
        check_idle("rnd_idle");
      end else begin
        run_op(r[0], r[1], 2'($urandom), 2'($urandom),
               W'($urandom), W'($urandom));
      end
    end

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
